// File: rtl/spi_shift_core.sv
// spi_shift_core
// Master-side SPI byte shifter: generates sclk from a programmable baud
// half-period, shifts one byte out on mosi and one byte in from miso, and
// raises a one-cycle receivedata pulse when the byte completes.
//
// Ports
//   pclk, preset        system clock, synchronous active-high reset
//   mstr, spe, spiswai  master / enable / stop-in-wait control bits
//   cpol, cpha, lsbfe   clock polarity, clock phase, LSB-first select
//   sppr, spr           baud prescaler and rate select, H = (sppr+1) << spr
//   spimode             00 run, 01 wait, 10 stop
//   senddata            transfer request, only looked at while idle
//   mosidata            byte to transmit
//   miso                serial input
//   sclk, mosi, ss      serial clock, serial output, active-low slave select
//   tip                 transfer in progress
//   receivedata         one-cycle pulse when a byte has been received
//   misodata            last completely received byte
//
// Handshake: senddata is a level request accepted only in IDLE when the
// block is enabled; there is no back-pressure. receivedata is a one-cycle
// strobe; misodata is loaded during that same cycle and is stable from the
// following cycle until the next completed byte.
module spi_shift_core #(
    parameter int         CNT_W   = 11,
    parameter logic [1:0] SPISTOP = 2'b10
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       mstr,
    input  logic       spe,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic       spiswai,
    input  logic [2:0] sppr,
    input  logic [2:0] spr,
    input  logic [1:0] spimode,
    input  logic       senddata,
    input  logic [7:0] mosidata,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss,
    output logic       tip,
    output logic       receivedata,
    output logic [7:0] misodata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         tx_sh_q, tx_sh_d;
    logic [7:0]         rx_sh_q, rx_sh_d;
    logic               cpol_l_q, cpol_l_d;
    logic               cpha_l_q, cpha_l_d;
    logic               lsbfe_l_q, lsbfe_l_d;
    logic [CNT_W-1:0]   h_q, h_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         edge_q, edge_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [7:0]         misodata_q, misodata_d;

    logic               enable;
    logic [CNT_W-1:0]   h_calc;
    logic               wrap;
    logic [4:0]         edge_nxt;
    logic               leading;
    logic               sample;
    logic [7:0]         tx_shifted;

    // The bit that drives mosi for a given shift register content.
    function automatic logic out_bit(input logic [7:0] v, input logic lsb);
        return lsb ? v[0] : v[7];
    endfunction

    // Stop mode never enables; wait mode enables unless stop-in-wait is set.
    assign enable = mstr & spe & (spimode != SPISTOP) &
                    ((spimode == 2'b00) | ((spimode == 2'b01) & ~spiswai));

    // H ranges 1..1024, so it needs 11 bits; the counter only reaches H-1.
    assign h_calc = {{(CNT_W-4){1'b0}}, 4'({1'b0, sppr} + 4'd1)} << spr;

    assign wrap       = (cnt_q == (h_q - 1'b1));
    assign edge_nxt   = edge_q + 5'd1;
    assign leading    = edge_nxt[0];
    assign sample     = cpha_l_q ? ~leading : leading;
    assign tx_shifted = lsbfe_l_q ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};

    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        cpol_l_d   = cpol_l_q;
        cpha_l_d   = cpha_l_q;
        lsbfe_l_d  = lsbfe_l_q;
        h_d        = h_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        misodata_d = misodata_q;

        case (state_q)
            IDLE: begin
                if (senddata && enable) begin
                    state_d   = XFER;
                    tx_sh_d   = mosidata;
                    cpol_l_d  = cpol;
                    cpha_l_d  = cpha;
                    lsbfe_l_d = lsbfe;
                    h_d       = h_calc;
                    cnt_d     = '0;
                    edge_d    = '0;
                    rx_sh_d   = '0;
                    sclk_d    = cpol;
                    // Phase 0 must have the first bit on the wire before edge 1.
                    if (!cpha) begin
                        mosi_d = out_bit(mosidata, lsbfe);
                    end
                end
            end

            XFER: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (wrap) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;

                    if (sample) begin
                        rx_sh_d = lsbfe_l_q ? {miso, rx_sh_q[7:1]} : {rx_sh_q[6:0], miso};
                    end

                    // Seven shifts per byte: phase 1 presents bit 0 on edge 1
                    // without shifting; phase 0 keeps the last bit through
                    // edge 16 so mosi idles at the final bit.
                    if (cpha_l_q) begin
                        if (leading) begin
                            if (edge_nxt != 5'd1) begin
                                tx_sh_d = tx_shifted;
                                mosi_d  = out_bit(tx_shifted, lsbfe_l_q);
                            end else begin
                                mosi_d  = out_bit(tx_sh_q, lsbfe_l_q);
                            end
                        end
                    end else if (!leading && (edge_nxt != 5'd16)) begin
                        tx_sh_d = tx_shifted;
                        mosi_d  = out_bit(tx_shifted, lsbfe_l_q);
                    end

                    if (edge_nxt == 5'd16) begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                misodata_d = rx_sh_q;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= IDLE;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cpol_l_q   <= 1'b0;
            cpha_l_q   <= 1'b0;
            lsbfe_l_q  <= 1'b0;
            h_q        <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            misodata_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            cpol_l_q   <= cpol_l_d;
            cpha_l_q   <= cpha_l_d;
            lsbfe_l_q  <= lsbfe_l_d;
            h_q        <= h_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            misodata_q <= misodata_d;
        end
    end

    // Idle sclk follows the live cpol input, but is forced low under reset.
    assign sclk        = (state_q == IDLE) ? (cpol & ~preset) : sclk_q;
    assign mosi        = mosi_q;
    assign ss          = (state_q != XFER);
    assign tip         = (state_q == XFER);
    assign receivedata = (state_q == DONE);
    assign misodata    = misodata_q;

endmodule

// File: tb/tb_spi_shift_core.sv
// Directed bench for spi_shift_core: loopback and tied-miso transfers,
// baud timing, mode 3 polarity, abort on enable loss, reset mid-transfer.
module tb_spi_shift_core;

    logic       pclk = 1'b0;
    logic       preset;
    logic       mstr, spe, cpol, cpha, lsbfe, spiswai;
    logic [2:0] sppr, spr;
    logic [1:0] spimode;
    logic       senddata;
    logic [7:0] mosidata;
    logic       miso;
    logic       sclk, mosi, ss, tip, receivedata;
    logic [7:0] misodata;

    logic       loop_en;
    logic       miso_val;

    int checks = 0;
    int errors = 0;

    assign miso = loop_en ? mosi : miso_val;

    always #5 pclk = ~pclk;

    spi_shift_core #(.CNT_W(11), .SPISTOP(2'b10)) dut (
        .pclk(pclk), .preset(preset),
        .mstr(mstr), .spe(spe), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe),
        .spiswai(spiswai), .sppr(sppr), .spr(spr), .spimode(spimode),
        .senddata(senddata), .mosidata(mosidata), .miso(miso),
        .sclk(sclk), .mosi(mosi), .ss(ss), .tip(tip),
        .receivedata(receivedata), .misodata(misodata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge. Requests a transfer and watches it to the end.
    task automatic run_xfer(input bit scramble,
                            output int tip_cyc, output int pulses,
                            output logic [7:0] lead_bits, output int n_lead,
                            output logic first_rise, output int per);
        logic ps, pm;
        int   n_edges, t, last_rise;
        bit   started, done;
        tip_cyc = 0; pulses = 0; lead_bits = '0; n_lead = 0;
        first_rise = 1'bx; per = 0;
        ps = 1'b0; pm = 1'b0; n_edges = 0; t = 0; last_rise = -1;
        started = 0; done = 0;
        senddata = 1'b1;
        while (!done && t < 3000) begin
            @(negedge pclk);
            senddata = 1'b0;
            t++;
            if (tip) begin
                if (started && sclk != ps) begin
                    n_edges++;
                    if (n_edges == 1) first_rise = sclk;
                    if (n_edges % 2 == 1) begin
                        lead_bits = {lead_bits[6:0], pm};
                        n_lead++;
                    end
                    if (sclk && !ps) begin
                        if (last_rise >= 0) per = t - last_rise;
                        last_rise = t;
                    end
                end
                if (!started && scramble) begin
                    sppr = 3'd0; spr = 3'd0; lsbfe = 1'b1; cpha = 1'b1;
                end
                started = 1;
                tip_cyc++;
                ps = sclk;
                pm = mosi;
            end
            if (receivedata) pulses++;
            if (started && !tip && !receivedata) done = 1;
        end
        chk("xfer_completes", 32'(done), 32'd1);
    endtask

    // Entered at a negedge. Requests a transfer and returns at the negedge
    // just after the n-th sclk edge.
    task automatic start_and_wait_edges(input int n);
        logic ps;
        int   e, t;
        e = 0; t = 0;
        senddata = 1'b1;
        @(negedge pclk);
        senddata = 1'b0;
        ps = sclk;
        while (e < n && t < 3000) begin
            @(negedge pclk);
            t++;
            if (tip && sclk != ps) e++;
            ps = sclk;
        end
        chk("edge_wait", 32'(e), 32'(n));
    endtask

    int         tc, pu, nl, pr, cnt;
    logic [7:0] lb;
    logic       fr;

    initial begin
        preset = 1'b1; mstr = 1'b1; spe = 1'b1; cpol = 1'b0; cpha = 1'b0;
        lsbfe = 1'b0; spiswai = 1'b0; sppr = 3'd0; spr = 3'd0;
        spimode = 2'b00; senddata = 1'b0; mosidata = 8'h00;
        loop_en = 1'b1; miso_val = 1'b0;

        // Reset state
        repeat (3) @(negedge pclk);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_ss", 32'(ss), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_tip", 32'(tip), 32'd0);
        chk("rst_rxd", 32'(receivedata), 32'd0);
        chk("rst_misodata", 32'(misodata), 32'h00);
        preset = 1'b0;
        @(negedge pclk);

        // No start while disabled
        spe = 1'b0; senddata = 1'b1; cnt = 0;
        repeat (4) begin
            @(negedge pclk);
            if (tip) cnt++;
        end
        senddata = 1'b0; spe = 1'b1;
        chk("disabled_no_start", 32'(cnt), 32'd0);
        @(negedge pclk);

        // Mode 0, MSB first, H=1, A5 loopback
        mosidata = 8'hA5;
        run_xfer(0, tc, pu, lb, nl, fr, pr);
        chk("a5_tip_cycles", 32'(tc), 32'd16);
        chk("a5_mosi_bits", 32'(lb), 32'hA5);
        chk("a5_nbits", 32'(nl), 32'd8);
        chk("a5_pulses", 32'(pu), 32'd1);
        chk("a5_misodata", 32'(misodata), 32'hA5);
        chk("a5_sclk_period", 32'(pr), 32'd2);
        chk("a5_idle_ss", 32'(ss), 32'd1);

        // LSB first, 01, miso tied high
        lsbfe = 1'b1; mosidata = 8'h01; loop_en = 1'b0; miso_val = 1'b1;
        run_xfer(0, tc, pu, lb, nl, fr, pr);
        chk("lsb_mosi_bits", 32'(lb), 32'h80);
        chk("lsb_misodata", 32'(misodata), 32'hFF);
        chk("lsb_pulses", 32'(pu), 32'd1);

        // H=6, with control inputs disturbed mid-transfer
        lsbfe = 1'b0; loop_en = 1'b1; sppr = 3'd2; spr = 3'd1; mosidata = 8'h5A;
        run_xfer(1, tc, pu, lb, nl, fr, pr);
        chk("h6_tip_cycles", 32'(tc), 32'd96);
        chk("h6_sclk_period", 32'(pr), 32'd12);
        chk("h6_mosi_bits", 32'(lb), 32'h5A);
        chk("h6_misodata", 32'(misodata), 32'h5A);

        // Mode 3, 3C loopback, H=1
        sppr = 3'd0; spr = 3'd0; lsbfe = 1'b0; cpol = 1'b1; cpha = 1'b1;
        mosidata = 8'h3C;
        @(negedge pclk);
        chk("m3_idle_sclk", 32'(sclk), 32'd1);
        run_xfer(0, tc, pu, lb, nl, fr, pr);
        chk("m3_first_edge_rising", 32'(fr), 32'd0);
        chk("m3_tip_cycles", 32'(tc), 32'd16);
        chk("m3_misodata", 32'(misodata), 32'h3C);
        chk("m3_pulses", 32'(pu), 32'd1);

        // Abort: spe dropped after edge 5, H=6
        sppr = 3'd2; spr = 3'd1; mosidata = 8'hC3;
        start_and_wait_edges(5);
        spe = 1'b0;
        @(negedge pclk);
        chk("abort_ss", 32'(ss), 32'd1);
        chk("abort_tip", 32'(tip), 32'd0);
        cnt = 0;
        repeat (100) begin
            @(negedge pclk);
            if (receivedata) cnt++;
        end
        chk("abort_no_pulse", 32'(cnt), 32'd0);
        chk("abort_misodata", 32'(misodata), 32'h3C);
        spe = 1'b1;
        @(negedge pclk);

        // Reset at edge 9 (cpol still 1: sclk must still read 0)
        start_and_wait_edges(9);
        preset = 1'b1;
        @(negedge pclk);
        chk("mid_rst_sclk", 32'(sclk), 32'd0);
        chk("mid_rst_ss", 32'(ss), 32'd1);
        chk("mid_rst_mosi", 32'(mosi), 32'd0);
        chk("mid_rst_tip", 32'(tip), 32'd0);
        chk("mid_rst_rxd", 32'(receivedata), 32'd0);
        chk("mid_rst_misodata", 32'(misodata), 32'h00);
        preset = 1'b0;
        cpol = 1'b0; cpha = 1'b0; sppr = 3'd0; spr = 3'd0; mosidata = 8'h96;
        @(negedge pclk);
        run_xfer(0, tc, pu, lb, nl, fr, pr);
        chk("post_rst_tip_cycles", 32'(tc), 32'd16);
        chk("post_rst_misodata", 32'(misodata), 32'h96);
        chk("post_rst_pulses", 32'(pu), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
